// File: rtl/bcd_count_ctrl.sv
// Round-robin, handshaked increment controller for an NDIG-digit BCD counter; ripples one digit per clock.
// Optional BCD_CTRL_SATURATE_EN: an increment at all-9s holds the value and reports overflow instead of wrapping.
module bcd_count_ctrl #(
  parameter int NDIG = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic [1:0]        req,
  output logic [1:0]        ack,
  output logic [4*NDIG-1:0] bcd,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [1:0]        o_dbg_state
);

  // Handshake: req is a level held until ack; ack is a one-cycle, one-hot pulse
  // during the first cycle after the grant edge, and the requester drops req in
  // that cycle (a req still high afterwards is a new request).

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIG - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RIPPLE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [4*NDIG-1:0] r_bcd, w_bcd_nxt;
  logic [IW-1:0]     r_idx, w_idx_nxt;
  logic              r_wrap, w_wrap_nxt;
  logic [1:0]        r_ack, w_ack_nxt;
  logic              r_last, w_last_nxt;   // 1: req[1] was granted last
  logic [1:0]        w_gnt;
  logic [3:0]        w_dig;

`ifdef BCD_CTRL_SATURATE_EN
  logic w_all9;
  always_comb begin
    w_all9 = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (r_bcd[4*i +: 4] != 4'd9) w_all9 = 1'b0;
    end
  end
`endif

  always_comb begin
    case (req)
      2'b01:   w_gnt = 2'b01;
      2'b10:   w_gnt = 2'b10;
      2'b11:   w_gnt = r_last ? 2'b01 : 2'b10;
      default: w_gnt = 2'b00;
    endcase
  end

  assign w_dig = r_bcd[{r_idx, 2'b00} +: 4];

  always_comb begin
    w_state_nxt = r_state;
    w_bcd_nxt   = r_bcd;
    w_idx_nxt   = r_idx;
    w_wrap_nxt  = r_wrap;
    w_ack_nxt   = 2'b00;
    w_last_nxt  = r_last;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_ack_nxt  = w_gnt;
          w_last_nxt = w_gnt[1];
          w_idx_nxt  = '0;
`ifdef BCD_CTRL_SATURATE_EN
          if (w_all9) begin
            w_wrap_nxt  = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_RIPPLE;
          end
`else
          w_state_nxt = S_RIPPLE;
`endif
        end
      end
      S_RIPPLE: begin
        if (w_dig == 4'd9) begin
          w_bcd_nxt[{r_idx, 2'b00} +: 4] = 4'd0;
          if (r_idx == LAST_IDX) begin
            w_wrap_nxt  = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end else begin
          w_bcd_nxt[{r_idx, 2'b00} +: 4] = w_dig + 4'd1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_wrap_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Clear overrides everything; an aborted increment keeps its grant (pointer already moved).
    if (clr) begin
      w_state_nxt = S_IDLE;
      w_bcd_nxt   = '0;
      w_idx_nxt   = '0;
      w_wrap_nxt  = 1'b0;
      w_ack_nxt   = 2'b00;
      w_last_nxt  = r_last;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_bcd   <= '0;
      r_idx   <= '0;
      r_wrap  <= 1'b0;
      r_ack   <= 2'b00;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_bcd   <= w_bcd_nxt;
      r_idx   <= w_idx_nxt;
      r_wrap  <= w_wrap_nxt;
      r_ack   <= w_ack_nxt;
      r_last  <= w_last_nxt;
    end
  end

  assign ack         = r_ack;
  assign bcd         = r_bcd;
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE) && !clr;
  assign ovf         = done && r_wrap;
  assign o_dbg_state = r_state;

endmodule

// File: doc/bcd_count_ctrl.md
# bcd_count_ctrl

Sequencing controller for a multi-digit BCD counter register, shared between two increment requesters. Arbitrates round-robin between requesters, acknowledges each accepted request, and ripples the increment through the BCD digits one digit per clock. Raises done and overflow pulses. Sits between event sources (debounced button, timer tick) and the display/readout path. Replaces free-running combinational incrementing with a clocked, handshaked datapath.

## Interface
Parameters:
- NDIG, 3, number of BCD digits (≥1); counter width is 4*NDIG bits.

Ports:
- clk  in  1  single clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear; highest priority in every state.
- req  in  2  increment requests; level, held until matching ack.
- ack  out  2  one-hot, one-cycle grant acknowledge.
- bcd  out  4*NDIG  counter value, digit 0 in bits [3:0].
- busy  out  1  high whenever the FSM is not IDLE.
- done  out  1  one-cycle pulse when an increment completes.
- ovf  out  1  one-cycle pulse, coincident with done, on wrap (or saturation hit).

## Operation
- Reset values: bcd=0, ack=0, busy=0, done=0, ovf=0, state=IDLE, digit index=0, round-robin pointer favours req[0].
- States:
  - IDLE: if clr, bcd←0 and stay. Otherwise, if any req bit is set: grant, go to RIPPLE with idx=0. Otherwise stay.
  - RIPPLE: process digit idx.
    - Digit==9: digit←0. If idx<NDIG-1, then idx←idx+1 and stay. Otherwise set the wrap flag and go to DONE.
    - Digit<9: digit←digit+1, go to DONE.
  - DONE: done=1, ovf=wrap flag. Clear the wrap flag and return to IDLE.
- Arbitration:
  - Single requester: that requester is granted.
  - Both requesting: grant the one not granted last. The pointer updates only on a grant.
- ack: registered, high exactly during the first RIPPLE cycle for the granted requester.
  - A requester must deassert req in the cycle ack is seen.
  - A req still high after ack is treated as a new request.
- Requests arriving while busy are not granted. They stay pending (level) until IDLE.
- clr in RIPPLE or DONE:
  - bcd←0, state←IDLE, no done/ovf for the aborted increment.
  - The aborted request counts as consumed (ack already given).
- clr and req together in IDLE: clear wins, no grant, req remains pending.
- Digit values >9 (illegal) are never produced. The only load paths are reset, clr, and digit increments.

## Timing
- Grant edge E0: state→RIPPLE, ack=1 during the cycle after E0.
- Increment with k trailing 9s (k<NDIG):
  - Digits update over edges E1..E(k+1).
  - done=1 in the cycle after E(k+1).
  - busy high for k+2 cycles.
- Full wrap (all 9s):
  - NDIG ripple edges, then DONE with ovf=1.
  - busy high for NDIG+1 cycles.
- Minimum spacing between grants: 3 cycles (k=0).
- bcd intermediate values during ripple are visible. Consumers sample bcd on done.
- reset asserted mid-operation: all outputs to reset values immediately (async); no done.

## Configuration
- BCD_CTRL_SATURATE_EN undefined (default): counter wraps from all-9s to 0 with ovf pulse, as above.
- BCD_CTRL_SATURATE_EN defined: behaviour at the grant edge when bcd is all 9s:
  - The request is still acked.
  - FSM goes directly to DONE; bcd is unchanged.
  - done=1 and ovf=1 in the cycle after the grant edge.
  - All non-saturating behaviour is unchanged.

## Test plan
- Reset then req[0] pulse-held at bcd=000 -> ack=01 one cycle, bcd=001, done one cycle later, busy 2 cycles, ovf=0.
- Preload via 9 increments, then increment at 009 -> bcd=010 after 2 ripple cycles, busy 3 cycles; at 099 -> 100, busy 4 cycles.
- Count to 999 then increment:
  - default build: bcd=000, ovf=1 with done, busy 4 cycles.
  - BCD_CTRL_SATURATE_EN build: bcd stays 999, ack given, done=ovf=1 one cycle after the grant edge.
- req=11 held continuously for 6 grants -> ack alternates 01,10,01,10,01,10; bcd=006.
- clr asserted during RIPPLE of 099->100 -> bcd=000 next edge, state IDLE, no done/ovf. clr with req=01 in IDLE -> bcd=000, grant on the following cycle.
- reset asserted mid-ripple at 199 -> bcd=000, busy=0, ack=0 immediately without clock edge.
